// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
package wb_rr_arbiter_pkg;

  // Bus ownership: either nobody owns the slave port, or one master does.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  // Width of a master index; a single master still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of every Wishbone signal around the arbiter. All per-master buses
// are packed master i in slice [i*W +: W]. The slave modport is the
// arbiter's view; the master modport is the surrounding system (the bus
// masters plus the shared slave's response path).
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  // Master-side request buses
  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i;
  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i;
  logic [NUM_MASTERS*DW/8-1:0]   wbm_sel_i;
  logic [NUM_MASTERS-1:0]        wbm_we_i;
  logic [NUM_MASTERS-1:0]        wbm_cyc_i;
  logic [NUM_MASTERS-1:0]        wbm_stb_i;
  logic [NUM_MASTERS*3-1:0]      wbm_cti_i;
  logic [NUM_MASTERS*2-1:0]      wbm_bte_i;
  // Master-side responses
  logic [DW-1:0]                 wbm_dat_o;
  logic [NUM_MASTERS-1:0]        wbm_ack_o;
  logic [NUM_MASTERS-1:0]        wbm_err_o;
  logic [NUM_MASTERS-1:0]        wbm_rty_o;
  // Shared slave request
  logic [AW-1:0]                 wbs_adr_o;
  logic [DW-1:0]                 wbs_dat_o;
  logic [DW/8-1:0]               wbs_sel_o;
  logic                          wbs_we_o;
  logic                          wbs_cyc_o;
  logic                          wbs_stb_o;
  logic [2:0]                    wbs_cti_o;
  logic [1:0]                    wbs_bte_o;
  // Shared slave response
  logic [DW-1:0]                 wbs_dat_i;
  logic                          wbs_ack_i;
  logic                          wbs_err_i;
  logic                          wbs_rty_i;
  // Registered one-hot grant
  logic [NUM_MASTERS-1:0]        grant_o;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
           wbm_cti_i, wbm_bte_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
           wbs_cti_o, wbs_bte_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    output grant_o
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
           wbm_cti_i, wbm_bte_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
           wbs_cti_o, wbs_bte_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i,
    input  grant_o
  );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: the first requester found scanning
// ptr+1, ptr+2, ... (mod NUM_MASTERS) wins. ptr is the last winner, so a
// lone requester always wins regardless of where ptr points.
module wb_rr_pick
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IW          = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IW-1:0]          gnt_idx
);

  logic          found;
  int            slot;
  logic [IW-1:0] slot_idx;

  // Scan all slots starting just after the last winner; first hit wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise
    // paths that skip an assignment would infer a latch.
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    slot     = 0;
    slot_idx = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      slot = int'(ptr) + i;
      if (slot >= NUM_MASTERS) slot = slot - NUM_MASTERS;
      slot_idx = IW'(slot);
      if (!found && req[slot_idx]) begin
        found         = 1'b1;
        gnt[slot_idx] = 1'b1;
        gnt_idx       = slot_idx;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS masters share one slave port.
// The grant is held for the whole cyc so bursts pass unbroken, one dead idle
// cycle separates owners, and a watchdog ends stalled accesses with err.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  wb_rr_arbiter_if.slave bus
);

  localparam int IW  = idx_width(NUM_MASTERS);
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic [WDW-1:0]         wd_q, wd_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;

  logic                   own;
  logic                   g_cyc, g_stb;
  logic                   resp;
  logic                   wd_fire;

  logic [AW-1:0]          m_adr;
  logic [DW-1:0]          m_dat;
  logic [DW/8-1:0]        m_sel;
  logic                   m_we;
  logic [2:0]             m_cti;
  logic [1:0]             m_bte;

  wb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IW          (IW)
  ) u_pick (
    .req     (bus.wbm_cyc_i),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  assign own     = (state_q == ST_OWN);
  assign g_cyc   = own & |(grant_q & bus.wbm_cyc_i);
  assign g_stb   = g_cyc & |(grant_q & bus.wbm_stb_i);
  assign resp    = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
  assign wd_fire = (TIMEOUT > 0) && own && (wd_q == WDW'(TIMEOUT));

  // State, grant, last-winner pointer and watchdog registers.
  always_ff @(posedge wb_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!wb_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= IW'(NUM_MASTERS - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state logic: arbitrate only from IDLE, release when owner drops cyc.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.wbm_cyc_i) begin
          state_d = ST_OWN;
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
        end
      end
      ST_OWN: begin
        if (!g_cyc) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = gidx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Watchdog counts stalled strobe cycles; any response, idle strobe or a
  // firing clears it, so it never wraps.
  always_comb begin
    if ((TIMEOUT == 0) || !g_stb || resp || wd_fire) wd_d = '0;
    else                                              wd_d = wd_q + 1'b1;
  end

  // Request mux: the one-hot grant selects the owner's slice; zero when idle.
  always_comb begin
    m_adr = '0;
    m_dat = '0;
    m_sel = '0;
    m_we  = 1'b0;
    m_cti = '0;
    m_bte = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        m_adr = bus.wbm_adr_i[i*AW +: AW];
        m_dat = bus.wbm_dat_i[i*DW +: DW];
        m_sel = bus.wbm_sel_i[i*(DW/8) +: (DW/8)];
        m_we  = bus.wbm_we_i[i];
        m_cti = bus.wbm_cti_i[i*3 +: 3];
        m_bte = bus.wbm_bte_i[i*2 +: 2];
      end
    end
  end

  assign bus.wbs_adr_o = m_adr;
  assign bus.wbs_dat_o = m_dat;
  assign bus.wbs_sel_o = m_sel;
  assign bus.wbs_we_o  = m_we;
  assign bus.wbs_cti_o = m_cti;
  assign bus.wbs_bte_o = m_bte;
  // A watchdog firing withdraws the request so the slave sees the cycle end.
  assign bus.wbs_cyc_o = g_cyc & ~wd_fire;
  assign bus.wbs_stb_o = g_stb & ~wd_fire;

  // Responses reach only the owner; a late slave ack during a firing is dropped.
  assign bus.wbm_dat_o = bus.wbs_dat_i;
  assign bus.wbm_ack_o = (own && !wd_fire && bus.wbs_ack_i)   ? grant_q : '0;
  assign bus.wbm_err_o = (own && (wd_fire || bus.wbs_err_i))  ? grant_q : '0;
  assign bus.wbm_rty_o = (own && !wd_fire && bus.wbs_rty_i)   ? grant_q : '0;
  assign bus.grant_o   = grant_q;

endmodule
